// File: rtl/shwr_summary_fifo_pkg.sv
// Shared widths, record layout and capture FSM states for the shower summary FIFO.
// SHWR_SUMMARY_TIMESTAMP_EN adds a 32-bit trigger-start timestamp field to each record.
package shwr_summary_fifo_pkg;

    localparam int ADC_WIDTH                = 12;
    localparam int SHWR_AREA_WIDTH          = 19;
    localparam int SHWR_BASELINE_EXTRA_BITS = 2;
    localparam int SHWR_AREA_BINS           = 20;
    localparam int BASELINE_WIDTH           = ADC_WIDTH + SHWR_BASELINE_EXTRA_BITS;
    localparam int CAPTURE_DLY_DEFAULT      = SHWR_AREA_BINS + 4;
    localparam int TSTAMP_WIDTH             = 32;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StWaitLow
    } cap_state_e;

    typedef struct packed {
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
        logic [TSTAMP_WIDTH-1:0]    tstamp;
`endif
        logic [SHWR_AREA_WIDTH-1:0] integral;
        logic [ADC_WIDTH-1:0]       peak;
        logic [BASELINE_WIDTH-1:0]  baseline;
        logic                       saturated;
        logic                       trunc;
    } summary_rec_t;

    localparam int SHWR_SUMMARY_WIDTH = $bits(summary_rec_t);

endpackage

// File: rtl/shwr_summary_fifo_if.sv
// Capture inputs and readout port of one shower summary FIFO channel.
// SHWR_SUMMARY_TIMESTAMP_EN adds TSTAMP / RD_TSTAMP.
interface shwr_summary_fifo_if
    import shwr_summary_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int OVF_WIDTH  = 8
);
    logic                       TRIGGERED;
    logic [SHWR_AREA_WIDTH-1:0] INTEGRAL;
    logic [ADC_WIDTH-1:0]       PEAK;
    logic [BASELINE_WIDTH-1:0]  BASELINE;
    logic                       SATURATED;
    logic                       RD_EN;
    logic [SHWR_AREA_WIDTH-1:0] RD_INTEGRAL;
    logic [ADC_WIDTH-1:0]       RD_PEAK;
    logic [BASELINE_WIDTH-1:0]  RD_BASELINE;
    logic                       RD_SATURATED;
    logic                       RD_TRUNC;
    logic                       EMPTY;
    logic                       FULL;
    logic [DEPTH_LOG2:0]        COUNT;
    logic [OVF_WIDTH-1:0]       OVF_CNT;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
    logic [TSTAMP_WIDTH-1:0]    TSTAMP;
    logic [TSTAMP_WIDTH-1:0]    RD_TSTAMP;
`endif

    modport slave (
        input  TRIGGERED, INTEGRAL, PEAK, BASELINE, SATURATED, RD_EN,
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
        input  TSTAMP,
        output RD_TSTAMP,
`endif
        output RD_INTEGRAL, RD_PEAK, RD_BASELINE, RD_SATURATED, RD_TRUNC,
        output EMPTY, FULL, COUNT, OVF_CNT
    );

    modport master (
        output TRIGGERED, INTEGRAL, PEAK, BASELINE, SATURATED, RD_EN,
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
        output TSTAMP,
        input  RD_TSTAMP,
`endif
        input  RD_INTEGRAL, RD_PEAK, RD_BASELINE, RD_SATURATED, RD_TRUNC,
        input  EMPTY, FULL, COUNT, OVF_CNT
    );

endinterface

// File: rtl/shwr_summary_ram.sv
// Generic synchronous first-word-fall-through FIFO with registered count/empty/full.
// A read on a full FIFO frees the slot the same-cycle write lands in.
module shwr_summary_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q, full_q;
    logic                  rd_ok, wr_ok;

    assign rd_ok = rd_en & ~empty_q;
    assign wr_ok = wr_en & (~full_q | rd_ok);

    always_comb begin
        count_d = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == (DEPTH_LOG2 + 1)'(DEPTH));
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = count_q;

endmodule

// File: rtl/shwr_summary_fifo.sv
// Per-channel shower summary capture: latches one record per trigger and queues it for readout.
// SHWR_SUMMARY_TIMESTAMP_EN stores the trigger-start TSTAMP with each record.
module shwr_summary_fifo
    import shwr_summary_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = 2,
    parameter int CAPTURE_DLY = CAPTURE_DLY_DEFAULT,
    parameter int OVF_WIDTH   = 8
) (
    input logic                 CLK120,
    input logic                 RESET,
    shwr_summary_fifo_if.slave  bus
);
    localparam int CNT_W = $clog2(CAPTURE_DLY + 1);

    cap_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bin_cnt_q, bin_cnt_d;
    logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
    logic                capture, cap_trunc;
    logic                do_rd, do_wr, ovf_inc;
    logic                fifo_empty, fifo_full;
    logic [DEPTH_LOG2:0] fifo_count;
    summary_rec_t        wr_rec, rd_rec;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
    logic [TSTAMP_WIDTH-1:0] tstamp_q, tstamp_d;
`endif

    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        capture   = 1'b0;
        cap_trunc = 1'b0;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
        tstamp_d  = tstamp_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.TRIGGERED) begin
                    state_d   = StArmed;
                    bin_cnt_d = CNT_W'(1);
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
                    tstamp_d  = bus.TSTAMP;
`endif
                end
            end
            StArmed: begin
                // Early drop: upstream values are still valid on this edge.
                if (!bus.TRIGGERED) begin
                    capture   = 1'b1;
                    cap_trunc = 1'b1;
                    state_d   = StIdle;
                    bin_cnt_d = '0;
                end else if (bin_cnt_q == CNT_W'(CAPTURE_DLY)) begin
                    capture = 1'b1;
                    state_d = StWaitLow;
                end else begin
                    bin_cnt_d = bin_cnt_q + 1'b1;
                end
            end
            StWaitLow: begin
                if (!bus.TRIGGERED) begin
                    state_d   = StIdle;
                    bin_cnt_d = '0;
                end
            end
            default: begin
                state_d   = StIdle;
                bin_cnt_d = '0;
            end
        endcase
    end

    // Pop is applied before the write, so a full FIFO with a read accepts the record.
    assign do_rd   = bus.RD_EN & ~fifo_empty;
    assign do_wr   = capture & (~fifo_full | do_rd);
    assign ovf_inc = capture & fifo_full & ~do_rd;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_inc && (ovf_q != {OVF_WIDTH{1'b1}})) begin
            ovf_d = ovf_q + 1'b1;
        end
    end

    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state_q   <= StIdle;
            bin_cnt_q <= '0;
            ovf_q     <= '0;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
            tstamp_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bin_cnt_q <= bin_cnt_d;
            ovf_q     <= ovf_d;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
            tstamp_q  <= tstamp_d;
`endif
        end
    end

    always_comb begin
        wr_rec           = '0;
        wr_rec.integral  = bus.INTEGRAL;
        wr_rec.peak      = bus.PEAK;
        wr_rec.baseline  = bus.BASELINE;
        wr_rec.saturated = bus.SATURATED;
        wr_rec.trunc     = cap_trunc;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
        wr_rec.tstamp    = tstamp_q;
`endif
    end

    shwr_summary_ram #(
        .WIDTH      (SHWR_SUMMARY_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (CLK120),
        .rst     (RESET),
        .wr_en   (do_wr),
        .wr_data (wr_rec),
        .rd_en   (do_rd),
        .rd_data (rd_rec),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.RD_INTEGRAL  = rd_rec.integral;
    assign bus.RD_PEAK      = rd_rec.peak;
    assign bus.RD_BASELINE  = rd_rec.baseline;
    assign bus.RD_SATURATED = rd_rec.saturated;
    assign bus.RD_TRUNC     = rd_rec.trunc;
`ifdef SHWR_SUMMARY_TIMESTAMP_EN
    assign bus.RD_TSTAMP    = rd_rec.tstamp;
`endif
    assign bus.EMPTY        = fifo_empty;
    assign bus.FULL         = fifo_full;
    assign bus.COUNT        = fifo_count;
    assign bus.OVF_CNT      = ovf_q;

endmodule
